// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, data-memory wait, multi-cycle execute sequencing, deferred branch flush.
// Optional macro HAZARD_PERF_EN adds stall-cycle and flush performance counters.
module hazard_ctrl #(
  parameter int unsigned MD_CYCLES   = 4,
  parameter logic [2:0]  LOAD_WB_SRC = 3'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [1:0] id_dep_check,
  input  logic [4:0] ex_rd,
  input  logic [2:0] ex_wb_src,
  input  logic       ex_md_start,
  input  logic       ex_branch_taken,
  input  logic       dmem_req,
  input  logic       dmem_ready,
  output logic       stall_f,
  output logic       stall_d,
  output logic       stall_e,
  output logic       stall_m,
  output logic       flush_d,
  output logic       flush_e,
  output logic       flush_m,
  output logic       md_busy
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushes
`endif
);
  typedef enum logic {RUN, MD_BUSY} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(MD_CYCLES - 2);

  state_t     state;
  logic [3:0] cnt;
  logic       mem_wait, load_use, md_hold, ex_held, br_go, lu_go;

  assign mem_wait = dmem_req & ~dmem_ready;
  assign load_use = (ex_wb_src == LOAD_WB_SRC) & (ex_rd != 5'd0) &
                    ((id_dep_check[0] & (ex_rd == id_rs1)) |
                     (id_dep_check[1] & (ex_rd == id_rs2)));
  assign md_hold  = ((state == RUN) & ex_md_start) | ((state == MD_BUSY) & (cnt != 4'd0));
  assign ex_held  = mem_wait | md_hold;

  // A branch behind a held D/E waits in EX; the input stays asserted until it can flush.
  assign br_go = ex_branch_taken & ~ex_held;
  assign lu_go = load_use & ~ex_branch_taken & ~ex_held;

  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    stall_e = 1'b0;
    stall_m = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    flush_m = 1'b0;
    md_busy = 1'b0;
    if (!rst) begin
      stall_e = ex_held;
      stall_m = mem_wait;
      stall_f = (ex_held | lu_go) & ~br_go;
      stall_d = (ex_held | lu_go) & ~br_go;
      flush_d = br_go;
      flush_e = br_go | lu_go;
      flush_m = md_hold & ~mem_wait;
      md_busy = (state == MD_BUSY);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= 4'd0;
    end else begin
      case (state)
        RUN: if (ex_md_start) begin
          state <= MD_BUSY;
          cnt   <= CNT_LOAD;
        end
        MD_BUSY: begin
          if (cnt != 4'd0) cnt <= cnt - 4'd1;
          else             state <= RUN;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= 32'd0;
      perf_flushes      <= 32'd0;
    end else begin
      if (stall_f) perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (flush_d) perf_flushes      <= perf_flushes + 32'd1;
    end
  end
`endif
endmodule
